execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Pipeline stage directly downstream of operand fetch: takes the fetched operation, operands and
//  destination register, computes the ALU result, and presents it to register writeback.
//  Ops are single-cycle, except IMUL, which runs an iterative shift-add multiplier.
//  Has one output register with a valid/ready handshake on both sides; stalls OF while busy or
//  while writeback back-pressures.
// PARAMETERS
//  MUL_BITS_PER_CYC  8  multiplier bits retired per MUL cycle; must divide 64. MUL latency = 64/MUL_BITS_PER_CYC.
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  reset       in   1   synchronous, active-low reset
//  of_valid    in   1   OF presents an operation this cycle
//  of_ready    out  1   stage accepts the operation this cycle
//  of_nop      in   1   operation is a bubble; consumed, produces no output
//  oper        in   8   operation code (table below)
//  oper1       in   64  destination/first operand
//  oper2       in   64  source operand (register, memory value or immediate)
//  opsize      in   2   00=8b 01=16b 10=32b 11=64b
//  dstreg      in   4   destination register index
//  wb_valid    out  1   result held for writeback
//  wb_ready    in   1   writeback consumes the result this cycle
//  wb_we       out  1   write wb_result to wb_dstreg
//  wb_result   out  64  result, zero-extended above opsize
//  wb_size     out  2   opsize of the result; the register file merges partial widths
//  wb_dstreg   out  4   destination index
//  wb_flags    out  4   {OF,SF,ZF,CF} after this op
// BEHAVIOUR
//  Op codes:
//   00 ADD, 01 OR, 04 AND, 05 SUB, 06 XOR, 07 CMP, 08 MOV, 09 SHL, 0A SHR, 0B IMUL.
//   Any other code completes as a no-write: wb_we=0, flags unchanged.
//  Reset state:
//   All outputs 0, state=IDLE, flag register 0.
//   A reset during MUL aborts the op; no result is produced.
//  Handshake:
//   of_ready = (state==IDLE) && (!wb_valid || wb_ready), combinational.
//   Accept = of_valid && of_ready.
//   wb_valid stays high and all wb_* hold stable until wb_valid && wb_ready.
//   A simultaneous accept and drain is legal; the new result loads on that edge.
//  Latency:
//   Single-cycle ops: wb_valid is asserted on the edge after accept.
//   IMUL: 64/MUL_BITS_PER_CYC cycles in MUL, then wb_valid. Default is 8 cycles.
//  Nop: when of_nop=1 on accept, the op is consumed, wb_valid is not set, and flags are unchanged.
//  FSM:
//   IDLE -> MUL on accept of IMUL.
//   MUL -> MUL while count != 0; count decrements each cycle.
//   MUL -> IDLE when count hits 0, with wb_valid set.
//   of_ready is 0 throughout MUL.
//  Width rules:
//   Operands are masked to opsize before computing; the result is masked to opsize.
//   CF = carry-out (ADD) or borrow (SUB/CMP) at bit W-1+1.
//   OF = signed overflow at bit W-1.
//   SF = bit W-1; ZF = masked result == 0.
//  Flag updates:
//   AND/OR/XOR: CF=OF=0.
//   MOV and shifts: flags unchanged.
//   CMP: flags updated, wb_we=0, wb_valid still asserted.
//  Shifts: count = oper2[5:0] for 64b, oper2[4:0] otherwise.
//   A count >= W gives 0.
//   SHR is logical.
//  IMUL: unsigned shift-add of the masked operands; result = low W bits of the product.
//   CF=OF=1 iff any product bit >= W is set. SF and ZF follow the result.
//  Dest: wb_dstreg is the registered dstreg; wb_we=1 for ADD/OR/AND/SUB/XOR/MOV/SHL/SHR/IMUL.
// CONFIGURATION
//  EX_FLAGS_EN defined:
//   Flag logic and the flag register are built.
//   wb_flags is driven per the rules above.
//  EX_FLAGS_EN undefined:
//   No flag logic is built; wb_flags is tied to 4'b0.
//   IMUL still computes the full product internally.
//   All other behaviour is identical.
// TESTING
//  ADD 64b, oper1=FFFF_FFFF_FFFF_FFFF, oper2=1, dstreg=3:
//   -> next cycle wb_valid=1, wb_result=0, wb_we=1, wb_dstreg=3, flags {0,0,1,1}.
//  SUB 8b, oper1=0x80, oper2=0x01:
//   -> wb_result=0x7F, OF=1, CF=0, SF=0.
//   Upper oper bits of 0xABCD_0080 are ignored.
//  IMUL 32b, 0x0001_0000 * 0x0001_0000:
//   -> of_ready=0 for 8 cycles, then wb_result=0, CF=OF=1.
//   A second op offered during MUL is not accepted.
//  Back-pressure, 3 back-to-back ADDs with wb_ready=0 for 4 cycles:
//   -> the first result holds stable and of_ready=0.
//   After wb_ready=1, one result drains per cycle, in order, with none lost.
//  Reset low on the 4th MUL cycle, released:
//   -> wb_valid=0, of_ready=1 next cycle; no stale IMUL result appears.
//  CMP 16b, 0x1234 vs 0x1234, then of_nop=1:
//   -> first: wb_we=0, ZF=1.
//   -> nop: no wb_valid, flags retain ZF=1.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative shift-add IMUL behind one registered writeback slot.
// Optional flag logic is built when EX_FLAGS_EN is defined; otherwise wb_flags is tied to zero.
module execute_stage #(
  parameter int MUL_BITS_PER_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        of_valid,
  output logic        of_ready,
  input  logic        of_nop,
  input  logic [7:0]  oper,
  input  logic [63:0] oper1,
  input  logic [63:0] oper2,
  input  logic [1:0]  opsize,
  input  logic [3:0]  dstreg,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [63:0] wb_result,
  output logic [1:0]  wb_size,
  output logic [3:0]  wb_dstreg,
  output logic [3:0]  wb_flags
);

  localparam int MUL_CYCLES = 64 / MUL_BITS_PER_CYC;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_OR   = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_SUB  = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_CMP  = 8'h07;
  localparam logic [7:0] OP_MOV  = 8'h08;
  localparam logic [7:0] OP_SHL  = 8'h09;
  localparam logic [7:0] OP_SHR  = 8'h0A;
  localparam logic [7:0] OP_IMUL = 8'h0B;

  typedef enum logic {IDLE, MUL} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [127:0]  mul_acc, mul_cand, mul_acc_next;
  logic [63:0]   mul_plier, mul_res;
  logic [1:0]    mul_size;
  logic [3:0]    mul_dst;
  logic [63:0]   mask, a, b, alu_res;
  logic [5:0]    shamt;
  logic          alu_we, accept, start_mul, load_alu, mul_done;

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [6:0] size_bits(input logic [1:0] s);
    case (s)
      2'b00:   return 7'd8;
      2'b01:   return 7'd16;
      2'b10:   return 7'd32;
      default: return 7'd64;
    endcase
  endfunction

  assign mask      = size_mask(opsize);
  assign a         = oper1 & mask;
  assign b         = oper2 & mask;
  assign shamt     = (opsize == 2'b11) ? oper2[5:0] : {1'b0, oper2[4:0]};
  assign of_ready  = (state == IDLE) && (!wb_valid || wb_ready);
  assign accept    = of_valid && of_ready;
  assign start_mul = accept && !of_nop && (oper == OP_IMUL);
  assign load_alu  = accept && !of_nop && (oper != OP_IMUL);
  assign mul_done  = (state == MUL) && (count == '0);

  always_comb begin
    alu_res = '0;
    alu_we  = 1'b0;
    case (oper)
      OP_ADD: begin alu_res = (a + b) & mask; alu_we = 1'b1; end
      OP_OR:  begin alu_res = a | b;          alu_we = 1'b1; end
      OP_AND: begin alu_res = a & b;          alu_we = 1'b1; end
      OP_XOR: begin alu_res = a ^ b;          alu_we = 1'b1; end
      OP_SUB: begin alu_res = (a - b) & mask; alu_we = 1'b1; end
      OP_CMP: alu_res = (a - b) & mask;
      OP_MOV: begin alu_res = b;              alu_we = 1'b1; end
      OP_SHL: begin
        alu_we  = 1'b1;
        alu_res = ({1'b0, shamt} >= size_bits(opsize)) ? '0 : ((a << shamt) & mask);
      end
      OP_SHR: begin
        alu_we  = 1'b1;
        alu_res = ({1'b0, shamt} >= size_bits(opsize)) ? '0 : (a >> shamt);
      end
      default: ;
    endcase
  end

  // One multiplier slice per cycle: add the shifted multiplicand for each set multiplier bit.
  always_comb begin
    mul_acc_next = mul_acc;
    for (int i = 0; i < MUL_BITS_PER_CYC; i++) begin
      if (mul_plier[i]) mul_acc_next = mul_acc_next + (mul_cand << i);
    end
    mul_res = mul_acc_next[63:0] & size_mask(mul_size);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_mul) state_next = MUL;
      MUL:  if (count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_result <= '0;
      wb_size   <= '0;
      wb_dstreg <= '0;
      mul_acc   <= '0;
      mul_cand  <= '0;
      mul_plier <= '0;
      mul_size  <= '0;
      mul_dst   <= '0;
    end else begin
      state <= state_next;
      if (load_alu) begin
        wb_valid  <= 1'b1;
        wb_we     <= alu_we;
        wb_result <= alu_res;
        wb_size   <= opsize;
        wb_dstreg <= dstreg;
      end else if (mul_done) begin
        wb_valid  <= 1'b1;
        wb_we     <= 1'b1;
        wb_result <= mul_res;
        wb_size   <= mul_size;
        wb_dstreg <= mul_dst;
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
      if (start_mul) begin
        count     <= CW'(MUL_CYCLES - 1);
        mul_acc   <= '0;
        mul_cand  <= {64'b0, a};
        mul_plier <= b;
        mul_size  <= opsize;
        mul_dst   <= dstreg;
      end else if (state == MUL) begin
        count     <= count - 1'b1;
        mul_acc   <= mul_acc_next;
        mul_cand  <= mul_cand << MUL_BITS_PER_CYC;
        mul_plier <= mul_plier >> MUL_BITS_PER_CYC;
      end
    end
  end

`ifdef EX_FLAGS_EN
  logic [3:0]  flag_q, alu_flags, mul_flags;
  logic [64:0] wide_sum, wide_diff;
  logic [5:0]  msb, mul_msb;
  logic [6:0]  top;
  logic        zf, mul_ovf;

  function automatic logic [5:0] size_msb(input logic [1:0] s);
    case (s)
      2'b00:   return 6'd7;
      2'b01:   return 6'd15;
      2'b10:   return 6'd31;
      default: return 6'd63;
    endcase
  endfunction

  // Flags are {OF,SF,ZF,CF}; carry and borrow come from the bit just above the operand width.
  always_comb begin
    msb       = size_msb(opsize);
    top       = size_bits(opsize);
    wide_sum  = {1'b0, a} + {1'b0, b};
    wide_diff = {1'b0, a} - {1'b0, b};
    zf        = (alu_res == '0);
    alu_flags = flag_q;
    case (oper)
      OP_ADD: alu_flags = {(a[msb] == b[msb]) && (alu_res[msb] != a[msb]),
                           alu_res[msb], zf, wide_sum[top]};
      OP_SUB, OP_CMP: alu_flags = {(a[msb] != b[msb]) && (alu_res[msb] != a[msb]),
                                   alu_res[msb], zf, wide_diff[top]};
      OP_OR, OP_AND, OP_XOR: alu_flags = {1'b0, alu_res[msb], zf, 1'b0};
      default: ;
    endcase
    mul_msb = size_msb(mul_size);
    case (mul_size)
      2'b00:   mul_ovf = |mul_acc_next[127:8];
      2'b01:   mul_ovf = |mul_acc_next[127:16];
      2'b10:   mul_ovf = |mul_acc_next[127:32];
      default: mul_ovf = |mul_acc_next[127:64];
    endcase
    mul_flags = {mul_ovf, mul_res[mul_msb], mul_res == '0, mul_ovf};
  end

  always_ff @(posedge clk) begin
    if (!reset)        flag_q <= '0;
    else if (load_alu) flag_q <= alu_flags;
    else if (mul_done) flag_q <= mul_flags;
  end

  assign wb_flags = flag_q;
`else
  assign wb_flags = 4'b0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: scoreboard of expected writebacks popped on each drain.
// Flag expectations collapse to zero when EX_FLAGS_EN is undefined.
module tb_execute_stage;

  logic        clk, reset, of_valid, of_ready, of_nop, wb_valid, wb_ready, wb_we;
  logic [7:0]  oper;
  logic [63:0] oper1, oper2, wb_result;
  logic [1:0]  opsize, wb_size;
  logic [3:0]  dstreg, wb_dstreg, wb_flags;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        we;
    logic [1:0]  size;
    logic [3:0]  dst;
    logic [3:0]  flags;
    logic        chk_res;
  } exp_t;

  exp_t sb[$];

  execute_stage #(.MUL_BITS_PER_CYC(8)) dut (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_ready(of_ready), .of_nop(of_nop),
    .oper(oper), .oper1(oper1), .oper2(oper2), .opsize(opsize), .dstreg(dstreg),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_result(wb_result),
    .wb_size(wb_size), .wb_dstreg(wb_dstreg), .wb_flags(wb_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef EX_FLAGS_EN
    return f;
`else
    return 4'b0;
`endif
  endfunction

  function automatic exp_t mk(input logic [63:0] res, input logic we, input logic [1:0] size,
                              input logic [3:0] dst, input logic [3:0] flags, input logic chk);
    exp_t e;
    e.res = res; e.we = we; e.size = size; e.dst = dst; e.flags = fx(flags); e.chk_res = chk;
    return e;
  endfunction

  // Scoreboard: every drain handshake pops the oldest expected result and compares it.
  always @(negedge clk) begin
    exp_t e;
    if (reset && wb_valid && wb_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_output: got result=%h dst=%0d, required no output", wb_result, wb_dstreg);
      end else begin
        e = sb.pop_front();
        if (e.chk_res && wb_result !== e.res) begin
          n_fail++;
          $display("[TB] FAIL wb_result: got %h, required %h", wb_result, e.res);
        end
        n_cmp++;
        if (wb_we !== e.we) begin
          n_fail++;
          $display("[TB] FAIL wb_we: got %b, required %b (result %h)", wb_we, e.we, e.res);
        end
        n_cmp++;
        if (wb_size !== e.size || wb_dstreg !== e.dst) begin
          n_fail++;
          $display("[TB] FAIL wb_size_dst: got %0d/%0d, required %0d/%0d", wb_size, wb_dstreg, e.size, e.dst);
        end
        n_cmp++;
        if (wb_flags !== e.flags) begin
          n_fail++;
          $display("[TB] FAIL wb_flags: got %b, required %b (result %h)", wb_flags, e.flags, e.res);
        end
      end
    end
  end

  task automatic send(input logic [7:0] op, input logic [63:0] o1, input logic [63:0] o2,
                      input logic [1:0] sz, input logic [3:0] dst, input logic nop,
                      input logic push, input exp_t e);
    bit done = 0;
    @(negedge clk);
    oper = op; oper1 = o1; oper2 = o2; opsize = sz; dstreg = dst; of_nop = nop; of_valid = 1'b1;
    if (push) sb.push_back(e);
    for (int i = 0; i < 40 && !done; i++) begin
      if (of_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    of_valid = 1'b0;
    of_nop = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL send_timeout: op %h never accepted, required acceptance within 40 cycles", op);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; of_valid = 1'b0; of_nop = 1'b0; wb_ready = 1'b1;
    oper = '0; oper1 = '0; oper2 = '0; opsize = '0; dstreg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_we, wb_result, wb_size, wb_dstreg, wb_flags} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got v=%b we=%b r=%h s=%0d d=%0d f=%b, required all 0",
               wb_valid, wb_we, wb_result, wb_size, wb_dstreg, wb_flags);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (of_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_of_ready: got %b, required 1", of_ready);
    end
  endtask

  task automatic test_alu();
    send(8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b11, 4'd3, 1'b0, 1'b1, mk(64'h0, 1, 2'b11, 3, 4'b0011, 1));
    n_cmp++;
    if (wb_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL add_latency: wb_valid got %b one edge after accept, required 1", wb_valid);
    end
    wait_drain();
    send(8'h05, 64'hABCD_0080, 64'h01, 2'b00, 4'd1, 1'b0, 1'b1, mk(64'h7F, 1, 2'b00, 1, 4'b1000, 1));
    send(8'h01, 64'hF0F0, 64'h0F0F, 2'b01, 4'd2, 1'b0, 1'b1, mk(64'hFFFF, 1, 2'b01, 2, 4'b0100, 1));
    send(8'h04, 64'hFFFF_0000, 64'h0000_FFFF, 2'b10, 4'd4, 1'b0, 1'b1, mk(64'h0, 1, 2'b10, 4, 4'b0010, 1));
    send(8'h06, 64'h1FF, 64'h0F, 2'b00, 4'd5, 1'b0, 1'b1, mk(64'hF0, 1, 2'b00, 5, 4'b0100, 1));
    send(8'h08, 64'h0, 64'h1122_3344_5566_7788, 2'b11, 4'd6, 1'b0, 1'b1,
         mk(64'h1122_3344_5566_7788, 1, 2'b11, 6, 4'b0100, 1));
    wait_drain();
  endtask

  task automatic test_shift();
    send(8'h09, 64'h81, 64'd1, 2'b00, 4'd1, 1'b0, 1'b1, mk(64'h02, 1, 2'b00, 1, 4'b0100, 1));
    send(8'h09, 64'hFF, 64'd8, 2'b00, 4'd2, 1'b0, 1'b1, mk(64'h0, 1, 2'b00, 2, 4'b0100, 1));
    send(8'h0A, 64'h80, 64'd7, 2'b00, 4'd3, 1'b0, 1'b1, mk(64'h1, 1, 2'b00, 3, 4'b0100, 1));
    send(8'h0A, 64'h8000, 64'd15, 2'b01, 4'd4, 1'b0, 1'b1, mk(64'h1, 1, 2'b01, 4, 4'b0100, 1));
    send(8'h09, 64'h1, 64'h40, 2'b11, 4'd5, 1'b0, 1'b1, mk(64'h1, 1, 2'b11, 5, 4'b0100, 1));
    send(8'h0A, 64'h8000_0000_0000_0000, 64'd63, 2'b11, 4'd6, 1'b0, 1'b1, mk(64'h1, 1, 2'b11, 6, 4'b0100, 1));
    send(8'h09, 64'h1, 64'h3F, 2'b10, 4'd7, 1'b0, 1'b1, mk(64'h8000_0000, 1, 2'b10, 7, 4'b0100, 1));
    wait_drain();
  endtask

  task automatic test_imul();
    int stalled = 0;
    @(negedge clk);
    oper = 8'h0B; oper1 = 64'h0001_0000; oper2 = 64'h0001_0000; opsize = 2'b10; dstreg = 4'd9;
    of_nop = 1'b0; of_valid = 1'b1;
    sb.push_back(mk(64'h0, 1, 2'b10, 9, 4'b1011, 1));
    n_cmp++;
    if (of_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL imul_idle_ready: got %b, required 1", of_ready);
    end
    @(posedge clk);
    #1;
    oper = 8'h00; oper1 = 64'h1; oper2 = 64'h1; opsize = 2'b11; dstreg = 4'd5;
    sb.push_back(mk(64'h2, 1, 2'b11, 5, 4'b0000, 1));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (of_ready === 1'b0 && wb_valid === 1'b0) stalled++;
    end
    n_cmp++;
    if (stalled != 8) begin
      n_fail++;
      $display("[TB] FAIL imul_busy: stalled cycles got %0d, required 8", stalled);
    end
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL imul_latency: wb_valid got %b after 8 MUL cycles, required 1", wb_valid);
    end
    @(posedge clk);
    #1;
    of_valid = 1'b0;
    wait_drain();
    send(8'h0B, 64'h0F, 64'h11, 2'b00, 4'd2, 1'b0, 1'b1, mk(64'hFF, 1, 2'b00, 2, 4'b0100, 1));
    send(8'h0B, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 4'd3, 1'b0, 1'b1,
         mk(64'hFFFF_FFFF_FFFF_FFFE, 1, 2'b11, 3, 4'b1101, 1));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int held = 0;
    @(negedge clk);
    wb_ready = 1'b0;
    oper = 8'h00; oper1 = 64'h1; oper2 = 64'h2; opsize = 2'b01; dstreg = 4'd1; of_valid = 1'b1;
    sb.push_back(mk(64'h3, 1, 2'b01, 1, 4'b0000, 1));
    sb.push_back(mk(64'h8000, 1, 2'b01, 2, 4'b1100, 1));
    sb.push_back(mk(64'h0, 1, 2'b00, 4, 4'b0011, 1));
    @(posedge clk);
    #1;
    oper1 = 64'h7FFF; oper2 = 64'h1; dstreg = 4'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb_valid === 1'b1 && wb_result === 64'h3 && wb_dstreg === 4'd1 && of_ready === 1'b0) held++;
    end
    n_cmp++;
    if (held != 4) begin
      n_fail++;
      $display("[TB] FAIL backpressure_hold: stable stalled cycles got %0d, required 4", held);
    end
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    opsize = 2'b00; oper1 = 64'hFF; oper2 = 64'h1; dstreg = 4'd4;
    n_cmp++;
    if (sb.size() != 2 || wb_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drain_rate_1: pending got %0d valid %b, required 2 and 1", sb.size(), wb_valid);
    end
    @(posedge clk);
    #1;
    of_valid = 1'b0;
    n_cmp++;
    if (sb.size() != 1 || wb_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drain_rate_2: pending got %0d valid %b, required 1 and 1", sb.size(), wb_valid);
    end
    wait_drain();
  endtask

  task automatic test_reset_mul();
    bit stale = 0;
    send(8'h0B, 64'd3, 64'd5, 2'b11, 4'd7, 1'b0, 1'b0, mk(64'hF, 1, 2'b11, 7, 4'b0000, 1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    n_cmp++;
    if (wb_valid !== 1'b0 || of_ready !== 1'b1 || wb_flags !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL mul_reset: got valid=%b ready=%b flags=%b, required 0/1/0000", wb_valid, of_ready, wb_flags);
    end
    repeat (12) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) stale = 1;
    end
    n_cmp++;
    if (stale) begin
      n_fail++;
      $display("[TB] FAIL mul_reset_stale: got a result after aborted IMUL, required none");
    end
  endtask

  task automatic test_cmp_nop();
    bit seen = 0;
    send(8'h07, 64'h1234, 64'h1234, 2'b01, 4'd8, 1'b0, 1'b1, mk(64'h0, 0, 2'b01, 8, 4'b0010, 0));
    send(8'h55, 64'h1, 64'h1, 2'b10, 4'd9, 1'b0, 1'b1, mk(64'h0, 0, 2'b10, 9, 4'b0010, 0));
    wait_drain();
    send(8'h00, 64'h5, 64'h6, 2'b11, 4'd10, 1'b1, 1'b0, mk(64'hB, 1, 2'b11, 10, 4'b0000, 1));
    repeat (5) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL nop_output: got wb_valid during nop, required none");
    end
    n_cmp++;
    if (wb_flags !== fx(4'b0010)) begin
      n_fail++;
      $display("[TB] FAIL nop_flags: got %b, required %b", wb_flags, fx(4'b0010));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_shift();
    test_imul();
    test_back_to_back();
    test_reset_mul();
    test_cmp_nop();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
